fetch_controller: RTL

- Sequences a byte-wide, read-only instruction memory: owns the fetch PC, issues two byte reads per instruction and assembles them big-endian into one INSTRUCTION_WIDTH word.
- Buffers assembled instructions in a small FIFO with a valid/ready interface to decode.
- Sits between the instruction memory and the decode stage; accepts branch/jump redirects from execute.

---
 rtl/fetch_pkg.sv | 19 +
 rtl/fetch_controller_if.sv | 31 +++
 rtl/instr_fifo.sv | 77 +++++++
 rtl/fetch_controller.sv | 140 ++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the fetch controller slice.
package fetch_pkg;

    localparam int FETCH_ADDR_W   = 8;
    localparam int FETCH_DATA_W   = 8;
    localparam int FETCH_INSTR_W  = 16;
    localparam bit BYTE_ORDER_BIG = 1'b1;

    typedef enum logic [0:0] {
        S_HI = 1'b0,
        S_LO = 1'b1
    } fetch_state_e;

    typedef struct packed {
        logic [FETCH_INSTR_W-1:0] instr;
        logic [FETCH_ADDR_W-1:0]  pc;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_controller_if.sv
// Memory, redirect and decode-side signals of the fetch controller.
interface fetch_controller_if
    import fetch_pkg::*;
#(
    parameter int ADDRESS_WIDTH     = FETCH_ADDR_W,
    parameter int DATA_WIDTH        = FETCH_DATA_W,
    parameter int INSTRUCTION_WIDTH = FETCH_INSTR_W
);

    logic [ADDRESS_WIDTH-1:0]     mem_addr;
    logic                         mem_rd_en;
    logic [DATA_WIDTH-1:0]        mem_rdata;
    logic                         redirect_valid;
    logic [ADDRESS_WIDTH-1:0]     redirect_pc;
    logic                         instr_valid;
    logic                         instr_ready;
    logic [INSTRUCTION_WIDTH-1:0] instr;
    logic [ADDRESS_WIDTH-1:0]     instr_pc;
    logic                         align_fault;

    modport master (
        output mem_addr, mem_rd_en, instr_valid, instr, instr_pc, align_fault,
        input  mem_rdata, redirect_valid, redirect_pc, instr_ready
    );

    modport slave (
        input  mem_addr, mem_rd_en, instr_valid, instr, instr_pc, align_fault,
        output mem_rdata, redirect_valid, redirect_pc, instr_ready
    );

endinterface

// File: rtl/instr_fifo.sv
// Small registered FIFO holding assembled instructions; flush empties it in one cycle.
module instr_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 24
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   flush,
    input  logic                   push,
    input  logic [WIDTH-1:0]       push_data,
    input  logic                   pop,
    output logic [WIDTH-1:0]       head_data,
    output logic                   head_valid,
    output logic [$clog2(DEPTH):0] count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] FULL_COUNT = (PTR_W+1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W:0]   count_q, count_d;
    logic             do_push;
    logic             do_pop;

    // A push into a full buffer is legal only when the head leaves in the same cycle.
    always_comb begin
        mem_d    = mem_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        do_pop   = pop && (count_q != '0);
        do_push  = push && ((count_q != FULL_COUNT) || do_pop);

        if (flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) begin
                mem_d[wr_ptr_q] = push_data;
                wr_ptr_d        = wr_ptr_q + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    assign head_data  = mem_q[rd_ptr_q];
    assign head_valid = (count_q != '0);
    assign count      = count_q;

endmodule

// File: rtl/fetch_controller.sv
// Byte-wide instruction fetch: two reads per instruction, big-endian assembly, buffered to decode.
// Optional FETCH_ALIGN_CHECK_EN: odd redirect targets are forced even and flag align_fault.
module fetch_controller
    import fetch_pkg::*;
#(
    parameter int                         ADDRESS_WIDTH     = FETCH_ADDR_W,
    parameter int                         DATA_WIDTH        = FETCH_DATA_W,
    parameter int                         INSTRUCTION_WIDTH = FETCH_INSTR_W,
    parameter int                         PC_INCREMENT_VAL  = 2,
    parameter logic [ADDRESS_WIDTH-1:0]   RESET_PC          = '0,
    parameter int                         BUF_DEPTH         = 2
) (
    input  logic                clk,
    input  logic                reset,
    fetch_controller_if.master  bus
);

    localparam int                       CNT_W  = $clog2(BUF_DEPTH) + 1;
    localparam int                       ENTRY_W = INSTRUCTION_WIDTH + ADDRESS_WIDTH;
    localparam logic [ADDRESS_WIDTH-1:0] PC_INC = ADDRESS_WIDTH'(PC_INCREMENT_VAL);
    localparam logic [ADDRESS_WIDTH-1:0] ONE    = ADDRESS_WIDTH'(1);

    fetch_state_e             state_q, state_d;
    logic [ADDRESS_WIDTH-1:0] fetch_pc_q, fetch_pc_d;
    logic                     lo_pending_q, lo_pending_d;
    logic [DATA_WIDTH-1:0]    hi_q, hi_d;
    logic                     align_fault_q, align_fault_d;

    logic                     rd_req;
    logic [ADDRESS_WIDTH-1:0] rd_addr;
    logic [ADDRESS_WIDTH-1:0] hi_pc;
    logic                     space_ok;
    logic                     push;
    logic                     pop;
    fetch_entry_t             push_entry;
    fetch_entry_t             head_entry;
    logic                     head_valid;
    logic [CNT_W-1:0]         count;
    logic [ADDRESS_WIDTH-1:0] redirect_target;
    logic                     redirect_misaligned;

`ifdef FETCH_ALIGN_CHECK_EN
    assign redirect_misaligned = bus.redirect_pc[0];
    assign redirect_target     = {bus.redirect_pc[ADDRESS_WIDTH-1:1], 1'b0};
`else
    assign redirect_misaligned = 1'b0;
    assign redirect_target     = bus.redirect_pc;
`endif

    // A hi read issued alongside a push must target the instruction after the one being pushed.
    assign hi_pc    = lo_pending_q ? (fetch_pc_q + PC_INC) : fetch_pc_q;
    assign space_ok = (int'(count) + int'(lo_pending_q)) < BUF_DEPTH;
    assign pop      = head_valid && bus.instr_ready;

    always_comb begin
        state_d       = state_q;
        fetch_pc_d    = fetch_pc_q;
        lo_pending_d  = lo_pending_q;
        hi_d          = hi_q;
        align_fault_d = align_fault_q;
        rd_req        = 1'b0;
        rd_addr       = hi_pc;
        push          = 1'b0;
        push_entry    = '0;

        if (bus.redirect_valid) begin
            fetch_pc_d   = redirect_target;
            lo_pending_d = 1'b0;
            state_d      = S_HI;
            if (redirect_misaligned) begin
                align_fault_d = 1'b1;
            end
        end else begin
            if (lo_pending_q) begin
                push             = 1'b1;
                push_entry.instr = BYTE_ORDER_BIG ? {hi_q, bus.mem_rdata} : {bus.mem_rdata, hi_q};
                push_entry.pc    = fetch_pc_q;
                fetch_pc_d       = hi_pc;
                lo_pending_d     = 1'b0;
            end
            case (state_q)
                S_HI: begin
                    if (space_ok) begin
                        rd_req  = 1'b1;
                        rd_addr = hi_pc;
                        state_d = S_LO;
                    end
                end
                S_LO: begin
                    hi_d         = bus.mem_rdata;
                    rd_req       = 1'b1;
                    rd_addr      = fetch_pc_q + ONE;
                    lo_pending_d = 1'b1;
                    state_d      = S_HI;
                end
                default: state_d = S_HI;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= S_HI;
            fetch_pc_q    <= RESET_PC;
            lo_pending_q  <= 1'b0;
            hi_q          <= '0;
            align_fault_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            fetch_pc_q    <= fetch_pc_d;
            lo_pending_q  <= lo_pending_d;
            hi_q          <= hi_d;
            align_fault_q <= align_fault_d;
        end
    end

    instr_fifo #(
        .DEPTH (BUF_DEPTH),
        .WIDTH (ENTRY_W)
    ) u_instr_fifo (
        .clk        (clk),
        .reset      (reset),
        .flush      (bus.redirect_valid),
        .push       (push),
        .push_data  (push_entry),
        .pop        (pop),
        .head_data  (head_entry),
        .head_valid (head_valid),
        .count      (count)
    );

    // Reads are suppressed while reset is held so memory sees no stray strobe.
    assign bus.mem_rd_en   = rd_req && !reset;
    assign bus.mem_addr    = rd_addr;
    assign bus.instr_valid = head_valid;
    assign bus.instr       = head_entry.instr;
    assign bus.instr_pc    = head_entry.pc;
    assign bus.align_fault = align_fault_q;

endmodule
